// File: rtl/serial_rx_pkg.sv
// Types and helpers shared by the serial word receiver and its source-side controller.
package serial_rx_pkg;

  typedef enum logic {S_DATA, S_PAR} rx_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry output holding register with valid/ready handshake and sticky overrun flag.
module rx_hold_reg #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear_i) begin
      data_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (load_i) begin
      // A word arriving on the same edge as a transfer replaces the delivered one.
      if (!valid_q || ready_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_word_rx.sv
// Reassembles WIDTH-bit words from a strobed serial stream; PARITY_CHECK_EN adds an
// even-parity bit per word and drives par_err_o.
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ser_in_i,
  input  logic             bit_en_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  output logic             par_err_o
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_in, word;
  logic             done, par;
  logic [WIDTH:0]   hold_data;

  if (LSB_FIRST) begin : g_lsb_first
    assign shift_in = {ser_in_i, shift_q[WIDTH-1:1]};
  end else begin : g_msb_first
    assign shift_in = {shift_q[WIDTH-2:0], ser_in_i};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    word    = shift_in;
    par     = 1'b0;
    if (clear_i) begin
      state_d = S_DATA;
      cnt_d   = '0;
    end else if (bit_en_i) begin
      unique case (state_q)
        S_DATA: begin
          shift_d = shift_in;
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = S_PAR;
`else
            done = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR: begin
          state_d = S_DATA;
          done    = 1'b1;
          word    = shift_q;
          par     = (^shift_q) ^ ser_in_i;
        end
`endif
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  rx_hold_reg #(
    .Width(WIDTH + 1)
  ) u_hold (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .load_i   (done),
    .data_i   ({par, word}),
    .ready_i  (ready_i),
    .data_o   (hold_data),
    .valid_o  (valid_o),
    .overrun_o(overrun_o)
  );

  assign data_o    = hold_data[WIDTH-1:0];
  assign par_err_o = hold_data[WIDTH];

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: bit-list reference model plus directed vectors.
module tb_serial_word_rx;

  localparam int unsigned W = 4;
`ifdef PARITY_CHECK_EN
  localparam int unsigned Nb = W + 1;
`else
  localparam int unsigned Nb = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ser, bit_en, clear, ready;
  logic [W-1:0] data;
  logic         valid, ovr, perr;
  logic         m_ser, m_en, m_ready;
  logic [W-1:0] m_data;
  logic         m_valid, m_ovr, m_perr;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ser_in_i(ser), .bit_en_i(bit_en), .clear_i(clear),
    .data_o(data), .valid_o(valid), .ready_i(ready), .overrun_o(ovr), .par_err_o(perr)
  );

  serial_word_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .ser_in_i(m_ser), .bit_en_i(m_en), .clear_i(clear),
    .data_o(m_data), .valid_o(m_valid), .ready_i(m_ready), .overrun_o(m_ovr),
    .par_err_o(m_perr)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: list of received bits, word handed over when Nb bits collected.
  int           e_n, nx_n;
  logic [Nb-1:0] e_bits, nx_bits;
  logic [W-1:0] e_data, nx_data;
  logic         e_valid, nx_valid, e_ovr, nx_ovr, e_par, nx_par;

  always_comb begin
    logic [W-1:0] w;
    logic         p, fin;
    nx_n = e_n; nx_bits = e_bits; nx_data = e_data;
    nx_valid = e_valid; nx_ovr = e_ovr; nx_par = e_par;
    w = '0; p = 1'b0; fin = 1'b0;
    if (clear) begin
      nx_n = 0; nx_valid = 1'b0; nx_ovr = 1'b0; nx_par = 1'b0;
    end else begin
      if (bit_en) begin
        nx_bits[e_n] = ser;
        if (e_n + 1 == int'(Nb)) begin
          for (int i = 0; i < int'(W); i++) w[i] = nx_bits[i];
`ifdef PARITY_CHECK_EN
          p = ^nx_bits;
`endif
          fin = 1'b1;
          nx_n = 0;
        end else begin
          nx_n = e_n + 1;
        end
      end
      if (fin) begin
        if (!e_valid || ready) begin
          nx_data = w; nx_par = p; nx_valid = 1'b1;
        end else begin
          nx_ovr = 1'b1;
        end
      end else if (e_valid && ready) begin
        nx_valid = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_n <= 0; e_bits <= '0; e_data <= '0; e_valid <= 1'b0; e_ovr <= 1'b0; e_par <= 1'b0;
    end else begin
      e_n <= nx_n; e_bits <= nx_bits; e_data <= nx_data;
      e_valid <= nx_valid; e_ovr <= nx_ovr; e_par <= nx_par;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cyc_valid", 32'(valid), 32'(e_valid));
      check("cyc_overrun", 32'(ovr), 32'(e_ovr));
      if (e_valid) begin
        check("cyc_data", 32'(data), 32'(e_data));
        check("cyc_parerr", 32'(perr), 32'(e_par));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser = b; bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  function automatic logic [Nb-1:0] frame(input logic [W-1:0] w);
    logic [Nb-1:0] f;
    f[W-1:0] = w;
`ifdef PARITY_CHECK_EN
    f[W] = ^w;
`endif
    return f;
  endfunction

  task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input bit gaps);
    logic [Nb-1:0] f;
    f = frame(w);
    for (int i = 0; i < int'(Nb); i++) begin
      if (gaps) tick();
      if (i == int'(Nb) - 1 && rdy_last) ready = 1'b1;
      send_bit(f[i]);
    end
  endtask

  task automatic send_msb(input logic b);
    m_ser = b; m_en = 1'b1;
    tick();
    m_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ser = 1'b0; bit_en = 1'b0; clear = 1'b0; ready = 1'b0;
    m_ser = 1'b0; m_en = 1'b0; m_ready = 1'b0;
    repeat (2) tick();
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_overrun", 32'(ovr), 32'h0);
    check("reset_parerr", 32'(perr), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: reset mid-word, then 1,0,1,1 -> 4'hD
    send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    #2;
    check("t1_rst_valid", 32'(valid), 32'h0);
    check("t1_rst_data", 32'(data), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(4'hD, 1'b0, 1'b0);
    check("t1_data", 32'(data), 32'hD);
    check("t1_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    check("t1_taken", 32'(valid), 32'h0);

    // 2: bits 0,1,1,0 at half rate with Ready=1
    send_word(4'h6, 1'b0, 1'b1);
    check("t2_data", 32'(data), 32'h6);
    check("t2_valid", 32'(valid), 32'h1);
    tick();
    check("t2_one_cycle", 32'(valid), 32'h0);

    // 3: back-pressure overrun
    ready = 1'b0;
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    check("t3_data_held", 32'(data), 32'hA);
    check("t3_valid", 32'(valid), 32'h1);
    check("t3_overrun", 32'(ovr), 32'h1);
    ready = 1'b1;
    tick();
    check("t3_taken", 32'(valid), 32'h0);
    check("t3_overrun_sticky", 32'(ovr), 32'h1);
    ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3_clear_overrun", 32'(ovr), 32'h0);

    // 4: Ready on the edge the second word completes
    send_word(4'hA, 1'b0, 1'b0);
    check("t4_first", 32'(data), 32'hA);
    send_word(4'h5, 1'b1, 1'b0);
    check("t4_data", 32'(data), 32'h5);
    check("t4_valid", 32'(valid), 32'h1);
    check("t4_no_overrun", 32'(ovr), 32'h0);
    tick();
    check("t4_drained", 32'(valid), 32'h0);

    // 5: Clear with a bit strobed after 3 bits
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    clear = 1'b1; ser = 1'b1; bit_en = 1'b1;
    tick();
    clear = 1'b0; bit_en = 1'b0;
    check("t5_clear_valid", 32'(valid), 32'h0);
    send_word(4'hF, 1'b0, 1'b0);
    check("t5_data", 32'(data), 32'hF);
    check("t5_valid", 32'(valid), 32'h1);
    check("t5_overrun", 32'(ovr), 32'h0);
    tick();

    // 6: MSB-first instance, 1,0,0,0 -> 4'h8
    send_msb(1'b1); send_msb(1'b0); send_msb(1'b0); send_msb(1'b0);
`ifdef PARITY_CHECK_EN
    send_msb(1'b1);
`endif
    check("t6_msb_data", 32'(m_data), 32'h8);
    check("t6_msb_valid", 32'(m_valid), 32'h1);
    check("t6_msb_overrun", 32'(m_ovr), 32'h0);

`ifdef PARITY_CHECK_EN
    ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("t6_par_data", 32'(data), 32'h3);
    check("t6_par_err1", 32'(perr), 32'h1);
    tick();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    check("t6_par_data_ok", 32'(data), 32'h3);
    check("t6_par_err0", 32'(perr), 32'h0);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
